// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed program image over a byte stream,
// writes it into instruction memory, and holds the CPU in reset until a
// valid image is in place. Instruction fetch is a combinational read that
// returns zero outside the loaded region.
module rom_loader #(
  parameter int INST_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH_LOG2    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid_in,
  output logic                     byte_ready_out,
  input  logic                     restart_in,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  output logic [INST_WIDTH-1:0]    instruction_out,
  output logic                     cpu_rst_out,
  output logic                     load_done_out,
  output logic                     load_error_out
);

  localparam int          DEPTH         = 1 << DEPTH_LOG2;
  localparam logic [16:0] DEPTH_WORDS_C = 17'(DEPTH);

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [7:0]              hdr_hi_r;
  logic [7:0]              data_hi_r;
  logic [15:0]             waddr_r;
  logic [15:0]             loaded_len_r;
  logic                    ready_r;
  logic                    cpu_rst_r;
  logic                    done_r;
  logic                    error_r;
  logic [INST_WIDTH-1:0]   mem_r [0:DEPTH-1];

  logic                    accept_s;
  logic [15:0]             hdr_count_s;
  logic                    hdr_bad_s;
  logic                    last_word_s;
  logic                    pc_hit_s;
  logic                    wr_en_s;
  logic                    hdr_ok_s;
  logic                    clear_s;
  logic                    hdr_hi_load_s;
  logic                    data_hi_load_s;

  assign accept_s    = byte_valid_in & ready_r;
  assign hdr_count_s = {hdr_hi_r, byte_in};
  // A zero-length image or one larger than the memory is rejected.
  assign hdr_bad_s   = (hdr_count_s == 16'd0) || ({1'b0, hdr_count_s} > DEPTH_WORDS_C);
  assign last_word_s = ((waddr_r + 16'd1) == loaded_len_r);

  // Next-state decode and one-cycle datapath strobes; rst and restart win over bytes.
  always_comb begin
    next_state_s   = state_r;
    wr_en_s        = 1'b0;
    hdr_ok_s       = 1'b0;
    clear_s        = 1'b0;
    hdr_hi_load_s  = 1'b0;
    data_hi_load_s = 1'b0;
    if (rst) begin
      next_state_s = LEN_HI;
    end else if (restart_in) begin
      next_state_s = LEN_HI;
      clear_s      = 1'b1;
    end else begin
      case (state_r)
        LEN_HI: begin
          if (accept_s) begin
            next_state_s  = LEN_LO;
            hdr_hi_load_s = 1'b1;
          end else begin
            next_state_s = LEN_HI;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            if (hdr_bad_s) begin
              next_state_s = ERR;
            end else begin
              next_state_s = DATA_HI;
              hdr_ok_s     = 1'b1;
            end
          end else begin
            next_state_s = LEN_LO;
          end
        end
        DATA_HI: begin
          if (accept_s) begin
            next_state_s   = DATA_LO;
            data_hi_load_s = 1'b1;
          end else begin
            next_state_s = DATA_HI;
          end
        end
        DATA_LO: begin
          if (accept_s) begin
            wr_en_s      = 1'b1;
            next_state_s = last_word_s ? RUN : DATA_HI;
          end else begin
            next_state_s = DATA_LO;
          end
        end
        RUN:     next_state_s = RUN;
        ERR:     next_state_s = ERR;
        default: next_state_s = LEN_HI;
      endcase
    end
  end

  // Control state, header/data byte holding, write address, length and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= LEN_HI;
      hdr_hi_r     <= 8'd0;
      data_hi_r    <= 8'd0;
      waddr_r      <= 16'd0;
      loaded_len_r <= 16'd0;
      ready_r      <= 1'b1;
      cpu_rst_r    <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (hdr_hi_load_s) begin
        hdr_hi_r <= byte_in;
      end
      if (data_hi_load_s) begin
        data_hi_r <= byte_in;
      end
      if (clear_s) begin
        waddr_r      <= 16'd0;
        loaded_len_r <= 16'd0;
      end else if (hdr_ok_s) begin
        waddr_r      <= 16'd0;
        loaded_len_r <= hdr_count_s;
      end else if (wr_en_s) begin
        waddr_r <= waddr_r + 16'd1;
      end
      // ready tracks the state being entered so no byte is taken in RUN/ERR.
      ready_r   <= (next_state_s == LEN_HI) || (next_state_s == LEN_LO) ||
                   (next_state_s == DATA_HI) || (next_state_s == DATA_LO);
      // CPU-facing flags lag the state by one edge.
      cpu_rst_r <= (state_r != RUN);
      done_r    <= (state_r == RUN);
      error_r   <= (state_r == ERR);
    end
  end

  // Instruction memory write port; contents survive rst and restart.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[waddr_r[DEPTH_LOG2-1:0]] <= {data_hi_r, byte_in};
    end
  end

  assign pc_hit_s        = (32'(pc_in) < 32'(loaded_len_r));
  assign instruction_out = pc_hit_s ? mem_r[pc_in[DEPTH_LOG2-1:0]] : {INST_WIDTH{1'b0}};
  assign byte_ready_out  = ready_r;
  assign cpu_rst_out     = cpu_rst_r;
  assign load_done_out   = done_r;
  assign load_error_out  = error_r;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected values computed
// from an image-level model; a negedge monitor pops and compares.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic        restart_in = 1'b0;
  logic [15:0] pc_in = 16'd0;
  logic [15:0] instruction_out;
  logic        cpu_rst_out;
  logic        load_done_out;
  logic        load_error_out;

  rom_loader #(.INST_WIDTH(16), .ADDRESS_WIDTH(16), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out), .restart_in(restart_in), .pc_in(pc_in),
    .instruction_out(instruction_out), .cpu_rst_out(cpu_rst_out),
    .load_done_out(load_done_out), .load_error_out(load_error_out)
  );

  always #5 clk = ~clk;

  // status nibble = {ready, cpu_rst, done, error}
  localparam logic [3:0] ST_LOAD  = 4'b1100;
  localparam logic [3:0] ST_HOLD  = 4'b0100;
  localparam logic [3:0] ST_RUN   = 4'b0010;
  localparam logic [3:0] ST_ERR   = 4'b0101;

  typedef struct {
    int          kind;   // 0 = instruction fetch, 1 = status flags
    logic [15:0] pc;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  logic        probe = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] model_mem [0:1023];
  int          model_len = 0;
  logic [15:0] img_words[$];

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (probe) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: probe with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.kind == 0) begin
          mon_act = instruction_out;
        end else begin
          mon_act = {12'd0, byte_ready_out, cpu_rst_out, load_done_out, load_error_out};
        end
        if (mon_act !== mon_e.exp) begin
          failures++;
          $display("FAIL %s pc=%0d actual=%h expected=%h",
                   (mon_e.kind == 0) ? "instr" : "status", mon_e.pc, mon_act, mon_e.exp);
        end
      end
    end
  end

  function automatic logic [15:0] model_instr(input int pc);
    if (pc < model_len) return model_mem[pc];
    return 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_instr(input logic [15:0] pc);
    exp_t e;
    pc_in = pc;
    e.kind = 0; e.pc = pc; e.exp = model_instr(int'(pc));
    sb.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic probe_status(input logic [3:0] st);
    exp_t e;
    e.kind = 1; e.pc = pc_in; e.exp = {12'd0, st};
    sb.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    byte_valid_in = 1'b1;
    byte_in = b;
    tick();
    byte_valid_in = 1'b0;
    byte_in = 8'($urandom);
    repeat (stall) tick();
  endtask

  // Restart (with a junk byte offered the same cycle, which must be ignored).
  task automatic do_restart();
    restart_in = 1'b1;
    byte_valid_in = 1'b1;
    byte_in = 8'($urandom);
    tick();
    restart_in = 1'b0;
    byte_valid_in = 1'b0;
    model_len = 0;
    tick();
    probe_status(ST_LOAD);
  endtask

  // Reset (with a byte offered the same cycle, which must not be written).
  task automatic do_reset();
    rst = 1'b1;
    byte_valid_in = 1'b1;
    byte_in = 8'($urandom);
    tick();
    rst = 1'b0;
    byte_valid_in = 1'b0;
    model_len = 0;
    probe_status(ST_LOAD);
  endtask

  // Send header + img_words; cut>=0 stops after that many bytes and then
  // applies action (0 restart, 1 reset, 2 leave the load pending).
  task automatic load(input logic [15:0] count, input int smin, input int smax,
                      input int cut, input int action);
    bit          bad;
    int          total;
    int          n;
    int          stall;
    logic [7:0]  b;
    logic [15:0] w;
    bad   = (count == 16'd0) || (int'(count) > 1024);
    total = bad ? 2 : 2 + 2 * int'(count);
    n     = (cut >= 0 && cut < total) ? cut : total;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        b = count[15:8];
      end else if (i == 1) begin
        b = count[7:0];
      end else begin
        w = img_words[(i - 2) / 2];
        b = ((i % 2) == 0) ? w[15:8] : w[7:0];
      end
      stall = (i == n - 1 && n == total) ? 0 : int'($urandom_range(smax, smin));
      send_byte(b, stall);
      if (i == 1 && !bad) model_len = int'(count);
      if (i >= 3 && (i % 2) == 1) model_mem[(i - 3) / 2] = img_words[(i - 3) / 2];
      if (i == 1 && !bad && n > 2) probe_status(ST_LOAD);
    end
    if (n < total) begin
      if (action == 0) do_restart();
      else if (action == 1) do_reset();
    end else if (bad) begin
      probe_status(ST_HOLD);
      probe_status(ST_ERR);
    end else begin
      probe_status(ST_HOLD);
      probe_status(ST_RUN);
    end
  endtask

  initial begin
    int cnt;
    int r;
    int cut;
    for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    // Reset state: loading, CPU held, nothing visible.
    probe_status(ST_LOAD);
    probe_instr(16'd0);
    probe_instr(16'd5);
    probe_instr(16'd2000);

    // Basic 2-word image.
    img_words.delete();
    img_words.push_back(16'h0005);
    img_words.push_back(16'hEC10);
    load(16'd2, 0, 0, -1, 0);
    probe_instr(16'd0);
    probe_instr(16'd1);
    probe_instr(16'd2);

    // Bytes ignored while running.
    byte_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_in = 8'($urandom);
      tick();
    end
    byte_valid_in = 1'b0;
    probe_status(ST_RUN);
    probe_instr(16'd0);
    probe_instr(16'd1);

    // Same image with 3-cycle stalls between bytes.
    do_restart();
    img_words.delete();
    img_words.push_back(16'h0005);
    img_words.push_back(16'hEC10);
    load(16'd2, 3, 3, -1, 0);
    probe_instr(16'd0);
    probe_instr(16'd1);
    probe_instr(16'd2);

    // Rejected headers.
    do_restart();
    load(16'h0000, 0, 1, -1, 0);
    probe_instr(16'd0);
    do_restart();
    load(16'h0401, 0, 1, -1, 0);
    probe_instr(16'd0);
    do_restart();

    // Restart after the 4th byte of a 2-word image, then a 1-word image.
    img_words.delete();
    img_words.push_back(16'h5A5A);
    img_words.push_back(16'hA5A5);
    load(16'd2, 0, 1, 4, 0);
    img_words.delete();
    img_words.push_back(16'h1234);
    load(16'd1, 0, 1, -1, 0);
    probe_instr(16'd0);
    probe_instr(16'd1);

    // Restart from RUN and reload.
    do_restart();
    img_words.delete();
    img_words.push_back(16'hABCD);
    load(16'd1, 0, 2, -1, 0);
    probe_instr(16'd0);

    // Reset in DATA_LO with a byte offered: that word must not be written.
    do_restart();
    img_words.delete();
    img_words.push_back(16'h1111);
    img_words.push_back(16'h2222);
    load(16'd2, 0, 0, -1, 0);
    do_restart();
    img_words.delete();
    img_words.push_back(16'h3333);
    img_words.push_back(16'h4444);
    load(16'd2, 0, 0, 5, 1);
    load(16'd2, 0, 0, 2, 2);
    probe_instr(16'd0);
    probe_instr(16'd1);
    do_reset();

    // Largest legal image.
    img_words.delete();
    for (int i = 0; i < 1024; i++) img_words.push_back(16'($urandom));
    load(16'd1024, 0, 0, -1, 0);
    probe_instr(16'd0);
    probe_instr(16'd1023);
    probe_instr(16'd1024);
    probe_instr(16'hFFFF);

    // Randomized images, bad headers and interrupted loads.
    for (int it = 0; it < 25; it++) begin
      do_restart();
      r = int'($urandom_range(4, 0));
      if (r == 0) begin
        if ($urandom_range(1, 0) == 0) load(16'd0, 0, 2, -1, 0);
        else load(16'($urandom_range(65535, 1025)), 0, 2, -1, 0);
        probe_instr(16'd0);
      end else begin
        cnt = int'($urandom_range(12, 1));
        img_words.delete();
        for (int k = 0; k < cnt; k++) img_words.push_back(16'($urandom));
        cut = (r == 1) ? int'($urandom_range(2 * cnt + 1, 1)) : -1;
        load(16'(cnt), 0, 2, cut, 0);
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(1, 0) == 0) probe_instr(16'($urandom_range(cnt + 2, 0)));
          else probe_instr(16'($urandom));
        end
      end
    end

    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d leftover expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
